// File: rtl/pipe_pkg.sv
// Shared D->E pipeline types: datapath width, instruction-class field masks and the E-slot payload.
package pipe_pkg;

    localparam int XLEN = 32;

    // type[2:0] != 0 means the instruction has no rs2; type[4:3] != 0 means it has no rd
    localparam logic [4:0] NO_RS2_MASK = 5'b00111;
    localparam logic [4:0] NO_RD_MASK  = 5'b11000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [4:0]      typ;
        logic [4:0]      rd;
        logic            load;
        logic [15:0]     ctrl;
    } de_payload_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Latency: count visible the cycle after the increment request; no backpressure.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/de_pipe_stage.sv
// Decode->Execute slot: resolves operands (forward vs regfile), latches the instruction into E,
// injects a bubble on a D stall, kills the slot on flush. Latency 1 cycle; E held while ~ready_E.
module de_pipe_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = pipe_pkg::XLEN,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_D,
    output logic              ready_D,
    input  logic              stall_D,
    input  logic              flush,
    input  logic [XLEN-1:0]   pc_D,
    input  logic [4:0]        type_D,
    input  logic [4:0]        rd_D,
    input  logic              load_D,
    input  logic [XLEN-1:0]   imm_D,
    input  logic [15:0]       ctrl_D,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic [XLEN-1:0]   fwd_rs1,
    input  logic [XLEN-1:0]   fwd_rs2,
    input  logic              fwd_vld_rs1,
    input  logic              fwd_vld_rs2,
    output logic              valid_E,
    input  logic              ready_E,
    output logic [XLEN-1:0]   pc_E,
    output logic [XLEN-1:0]   imm_E,
    output logic [XLEN-1:0]   op1_E,
    output logic [XLEN-1:0]   op2_E,
    output logic [4:0]        type_E,
    output logic [4:0]        rd_E,
    output logic              load_E,
    output logic [15:0]       ctrl_E,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_bubble
);

    logic        r_valid_E;
    de_payload_t r_payload;
    de_payload_t w_payload_D;
    logic        w_fire;
    logic        w_drain;
    logic        w_stalled;
    logic        w_bubble;

    assign ready_D   = ~r_valid_E | ready_E;
    assign w_fire    = valid_D & ready_D & ~stall_D & ~flush;
    assign w_drain   = ready_E | ~r_valid_E;
    assign w_stalled = valid_D & stall_D;
    // A stall only becomes a bubble when E is free to move; a flush-kill is not a bubble
    assign w_bubble  = w_stalled & w_drain & ~flush;

    always_comb begin
        w_payload_D      = '0;
        w_payload_D.pc   = pc_D;
        w_payload_D.imm  = imm_D;
        w_payload_D.op1  = fwd_vld_rs1 ? fwd_rs1 : rf_rdata1;
        w_payload_D.op2  = fwd_vld_rs2 ? fwd_rs2 : rf_rdata2;
        w_payload_D.typ  = type_D;
        w_payload_D.rd   = rd_D;
        w_payload_D.load = load_D;
        w_payload_D.ctrl = ctrl_D;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_E <= 1'b0;
        end else if (flush) begin
            r_valid_E <= 1'b0;
        end else if (w_fire) begin
            r_valid_E <= 1'b1;
        end else if (w_drain) begin
            r_valid_E <= 1'b0;
        end
    end

    // Single enable keeps rd/load bit-stable for the hazard unit while E is backpressured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_payload <= '0;
        end else if (w_fire) begin
            r_payload <= w_payload_D;
        end
    end

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_stalled),
        .o_cnt (perf_stall)
    );

    sat_counter #(.W(PERF_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_bubble),
        .o_cnt (perf_bubble)
    );

    assign valid_E = r_valid_E;
    assign pc_E    = r_payload.pc;
    assign imm_E   = r_payload.imm;
    assign op1_E   = r_payload.op1;
    assign op2_E   = r_payload.op2;
    assign type_E  = r_payload.typ;
    assign rd_E    = r_payload.rd;
    assign load_E  = r_payload.load;
    assign ctrl_E  = r_payload.ctrl;

endmodule

// File: tb/tb_de_pipe_stage.sv
// Directed bench for de_pipe_stage with a narrow perf counter so saturation is reachable.
module tb_de_pipe_stage;

    localparam int XLEN   = 32;
    localparam int PERF_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              valid_D, ready_D, stall_D, flush;
    logic [XLEN-1:0]   pc_D, imm_D, rf_rdata1, rf_rdata2, fwd_rs1, fwd_rs2;
    logic [4:0]        type_D, rd_D;
    logic              load_D, fwd_vld_rs1, fwd_vld_rs2;
    logic [15:0]       ctrl_D;
    logic              valid_E, ready_E, load_E;
    logic [XLEN-1:0]   pc_E, imm_E, op1_E, op2_E;
    logic [4:0]        type_E, rd_E;
    logic [15:0]       ctrl_E;
    logic [PERF_W-1:0] perf_stall, perf_bubble;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    de_pipe_stage #(.XLEN(XLEN), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_D(valid_D), .ready_D(ready_D),
        .stall_D(stall_D), .flush(flush), .pc_D(pc_D), .type_D(type_D),
        .rd_D(rd_D), .load_D(load_D), .imm_D(imm_D), .ctrl_D(ctrl_D),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_rs1(fwd_rs1),
        .fwd_rs2(fwd_rs2), .fwd_vld_rs1(fwd_vld_rs1), .fwd_vld_rs2(fwd_vld_rs2),
        .valid_E(valid_E), .ready_E(ready_E), .pc_E(pc_E), .imm_E(imm_E),
        .op1_E(op1_E), .op2_E(op2_E), .type_E(type_E), .rd_E(rd_E),
        .load_E(load_E), .ctrl_E(ctrl_E), .perf_stall(perf_stall),
        .perf_bubble(perf_bubble)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        valid_D = 0; stall_D = 0; flush = 0; ready_E = 1;
        pc_D = 0; imm_D = 0; type_D = 0; rd_D = 0; load_D = 0; ctrl_D = 0;
        rf_rdata1 = 0; rf_rdata2 = 0; fwd_rs1 = 0; fwd_rs2 = 0;
        fwd_vld_rs1 = 0; fwd_vld_rs2 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        #12;
        chk("rst_valid_E", valid_E, 0);
        chk("rst_pc_E", pc_E, 0);
        chk("rst_op1_E", op1_E, 0);
        chk("rst_perf_stall", perf_stall, 0);
        chk("rst_perf_bubble", perf_bubble, 0);
        chk("rst_ready_D", ready_D, 1);
        rst_n = 1;
        tick();

        // back-to-back ADDs
        for (int i = 0; i < 4; i++) begin
            valid_D = 1; pc_D = 32'h100 + 32'(4 * i); rd_D = 5'(i + 1);
            rf_rdata1 = 32'h1000 + 32'(i); imm_D = 32'(i * 3); ctrl_D = 16'(16'hA0 + i);
            tick();
            chk("b2b_valid_E", valid_E, 1);
            chk("b2b_pc_E", pc_E, 64'h100 + 64'(4 * i));
            chk("b2b_rd_E", rd_E, 64'(i + 1));
            chk("b2b_op1_E", op1_E, 64'h1000 + 64'(i));
            chk("b2b_ctrl_E", ctrl_E, 64'hA0 + 64'(i));
        end

        // load-use: LW x5 then ADD x6,x5,x1 stalled one cycle
        do_reset();
        valid_D = 1; pc_D = 32'h200; rd_D = 5; load_D = 1; type_D = 5'b00001;
        tick();
        chk("lw_valid_E", valid_E, 1);
        chk("lw_load_E", load_E, 1);
        chk("lw_rd_E", rd_E, 5);
        pc_D = 32'h204; rd_D = 6; load_D = 0; type_D = 0; stall_D = 1;
        rf_rdata1 = 32'h11; fwd_rs1 = 32'h55;
        tick();
        chk("bub_valid_E", valid_E, 0);
        chk("bub_perf_bubble", perf_bubble, 1);
        chk("bub_perf_stall", perf_stall, 1);
        chk("bub_rd_E_kept", rd_E, 5);
        stall_D = 0; fwd_vld_rs1 = 1;
        tick();
        chk("add_valid_E", valid_E, 1);
        chk("add_op1_fwd", op1_E, 32'h55);
        chk("add_rd_E", rd_E, 6);
        chk("add_load_E", load_E, 0);
        chk("add_perf_bubble", perf_bubble, 1);
        chk("add_perf_stall", perf_stall, 1);

        // backpressure: E held for 3 cycles, one of them with a D stall
        ready_E = 0; pc_D = 32'h208; rd_D = 7; load_D = 1;
        fwd_vld_rs1 = 0; rf_rdata1 = 32'h99;
        for (int i = 0; i < 3; i++) begin
            stall_D = (i == 1);
            #1;
            chk("bp_ready_D", ready_D, 0);
            tick();
            chk("bp_valid_E", valid_E, 1);
            chk("bp_rd_E", rd_E, 6);
            chk("bp_op1_E", op1_E, 32'h55);
            chk("bp_load_E", load_E, 0);
            chk("bp_pc_E", pc_E, 32'h204);
        end
        chk("bp_perf_bubble", perf_bubble, 1);
        chk("bp_perf_stall", perf_stall, 2);

        // flush kills the transfer and the E contents
        stall_D = 0; ready_E = 1; flush = 1;
        #1;
        chk("fl_ready_D", ready_D, 1);
        tick();
        flush = 0; valid_D = 0;
        chk("fl_valid_E", valid_E, 0);
        chk("fl_pc_E_kept", pc_E, 32'h204);
        chk("fl_perf_bubble", perf_bubble, 1);
        chk("fl_perf_stall", perf_stall, 2);
        tick();
        chk("fl_dropped", valid_E, 0);

        // rs2 forward
        valid_D = 1; pc_D = 32'h300; fwd_vld_rs2 = 1; fwd_rs2 = 32'hDEAD_BEEF; rf_rdata2 = 0;
        tick();
        chk("fwd2_op2_E", op2_E, 32'hDEAD_BEEF);
        fwd_vld_rs2 = 0; rf_rdata2 = 32'h1234;
        tick();
        chk("rf2_op2_E", op2_E, 32'h1234);

        // counter saturation at 4'hF
        do_reset();
        valid_D = 1; stall_D = 1;
        for (int i = 0; i < 13; i++) tick();
        chk("sat_stall_13", perf_stall, 13);
        chk("sat_bubble_13", perf_bubble, 13);
        for (int i = 0; i < 4; i++) tick();
        chk("sat_stall_max", perf_stall, 15);
        chk("sat_bubble_max", perf_bubble, 15);
        chk("sat_valid_E", valid_E, 0);

        // async reset while E is held
        stall_D = 0; pc_D = 32'h400;
        tick();
        ready_E = 0;
        tick();
        chk("ar_held_valid", valid_E, 1);
        #1;
        rst_n = 0;
        #1;
        chk("ar_valid_E", valid_E, 0);
        chk("ar_pc_E", pc_E, 0);
        chk("ar_perf_stall", perf_stall, 0);
        rst_n = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
